// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//
// Assembles fixed 14-byte command frames from a received UART byte stream:
//   HEADER, FUNC, D1..D10, CSUM, TAIL
// CSUM is the 8-bit wrapping sum of FUNC and D1..D10. Only complete frames
// with a good checksum and tail update the outputs. Bad frames and stalled
// frames are discarded and counted.
//
// State table
//   state  | meaning
//   IDLE   | waiting for HEADER; other bytes are ignored
//   FUNC   | next byte is the function code; seeds the running sum
//   DATA   | collecting payload bytes D1..D10 (HEADER value is plain data here)
//   CSUM   | next byte must equal the running sum
//   TAIL   | next byte must equal TAIL; a match commits the frame
//
// Ports
//   clk_50M               system clock
//   rst                   asynchronous active-high reset
//   uart_rx_data[7:0]     received byte, valid while uart_rx_done=1
//   uart_rx_done          one-cycle byte strobe
//   func_reg[7:0]         function code of the last committed frame
//   rev_data1..10[7:0]    payload bytes of the last committed frame
//   pack_done             one-cycle pulse when outputs were just updated
//   frame_err             one-cycle pulse when a frame was discarded
//   err_cnt[7:0]          discarded frame count, saturates at 255
//   busy                  parser is inside a frame (state other than IDLE)

module uart_frame_parser #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter logic [7:0] TAIL        = 8'h5A,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         CNT_W       = 16
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_done,
    output logic [7:0] func_reg,
    output logic [7:0] rev_data1,
    output logic [7:0] rev_data2,
    output logic [7:0] rev_data3,
    output logic [7:0] rev_data4,
    output logic [7:0] rev_data5,
    output logic [7:0] rev_data6,
    output logic [7:0] rev_data7,
    output logic [7:0] rev_data8,
    output logic [7:0] rev_data9,
    output logic [7:0] rev_data10,
    output logic       pack_done,
    output logic       frame_err,
    output logic [7:0] err_cnt,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FUNC,
        S_DATA,
        S_CSUM,
        S_TAIL
    } state_t;

    // The timeout fires on the silent cycle whose increment would land on
    // TIMEOUT_CYC, so the counter itself never needs to hold that value.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic [7:0]       func_sh_q, func_sh_d;
    logic [7:0]       data_sh_q [10];
    logic [7:0]       data_sh_d [10];
    logic [7:0]       sum_q, sum_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [7:0]       func_reg_q, func_reg_d;
    logic [7:0]       rev_data_q [10];
    logic [7:0]       rev_data_d [10];
    logic             pack_done_q, pack_done_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic             commit;
    logic             err_evt;

    always_comb begin
        state_d     = state_q;
        func_sh_d   = func_sh_q;
        data_sh_d   = data_sh_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        func_reg_d  = func_reg_q;
        rev_data_d  = rev_data_q;
        pack_done_d = 1'b0;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        commit      = 1'b0;
        err_evt     = 1'b0;

        if (uart_rx_done) begin
            // A byte always wins over a timeout landing in the same cycle.
            tmo_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (uart_rx_data == HEADER) begin
                        state_d = S_FUNC;
                    end
                end
                S_FUNC: begin
                    func_sh_d = uart_rx_data;
                    sum_d     = uart_rx_data;
                    idx_d     = 4'd0;
                    state_d   = S_DATA;
                end
                S_DATA: begin
                    data_sh_d[idx_q] = uart_rx_data;
                    sum_d            = sum_q + uart_rx_data;
                    idx_d            = idx_q + 4'd1;
                    if (idx_q == 4'd9) begin
                        state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (uart_rx_data == sum_q) begin
                        state_d = S_TAIL;
                    end else begin
                        err_evt = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_TAIL: begin
                    if (uart_rx_data == TAIL) begin
                        commit = 1'b1;
                    end else begin
                        err_evt = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                err_evt = 1'b1;
                state_d = S_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + CNT_W'(1);
            end
        end else begin
            tmo_d = '0;
        end

        if (commit) begin
            func_reg_d  = func_sh_q;
            rev_data_d  = data_sh_q;
            pack_done_d = 1'b1;
        end

        if (err_evt) begin
            frame_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            func_sh_q   <= '0;
            data_sh_q   <= '{default: '0};
            sum_q       <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            func_reg_q  <= '0;
            rev_data_q  <= '{default: '0};
            pack_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            func_sh_q   <= func_sh_d;
            data_sh_q   <= data_sh_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            func_reg_q  <= func_reg_d;
            rev_data_q  <= rev_data_d;
            pack_done_q <= pack_done_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign func_reg   = func_reg_q;
    assign rev_data1  = rev_data_q[0];
    assign rev_data2  = rev_data_q[1];
    assign rev_data3  = rev_data_q[2];
    assign rev_data4  = rev_data_q[3];
    assign rev_data5  = rev_data_q[4];
    assign rev_data6  = rev_data_q[5];
    assign rev_data7  = rev_data_q[6];
    assign rev_data8  = rev_data_q[7];
    assign rev_data9  = rev_data_q[8];
    assign rev_data10 = rev_data_q[9];
    assign pack_done  = pack_done_q;
    assign frame_err  = frame_err_q;
    assign err_cnt    = err_cnt_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Testbench for uart_frame_parser: directed frames plus randomized traffic,
// every cycle compared against a byte-queue reference model.

module tb_uart_frame_parser;

    localparam int T = 16;

    logic       clk_50M = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] uart_rx_data = 8'h00;
    logic       uart_rx_done = 1'b0;
    logic [7:0] func_reg, err_cnt;
    logic [7:0] rev_data1, rev_data2, rev_data3, rev_data4, rev_data5;
    logic [7:0] rev_data6, rev_data7, rev_data8, rev_data9, rev_data10;
    logic       pack_done, frame_err, busy;
    logic [7:0] rd [10];

    assign rd[0] = rev_data1;
    assign rd[1] = rev_data2;
    assign rd[2] = rev_data3;
    assign rd[3] = rev_data4;
    assign rd[4] = rev_data5;
    assign rd[5] = rev_data6;
    assign rd[6] = rev_data7;
    assign rd[7] = rev_data8;
    assign rd[8] = rev_data9;
    assign rd[9] = rev_data10;

    always #10 clk_50M = ~clk_50M;

    uart_frame_parser #(
        .HEADER(8'hA5), .TAIL(8'h5A), .TIMEOUT_CYC(T), .CNT_W(8)
    ) dut (
        .clk_50M(clk_50M), .rst(rst),
        .uart_rx_data(uart_rx_data), .uart_rx_done(uart_rx_done),
        .func_reg(func_reg),
        .rev_data1(rev_data1), .rev_data2(rev_data2), .rev_data3(rev_data3),
        .rev_data4(rev_data4), .rev_data5(rev_data5), .rev_data6(rev_data6),
        .rev_data7(rev_data7), .rev_data8(rev_data8), .rev_data9(rev_data9),
        .rev_data10(rev_data10),
        .pack_done(pack_done), .frame_err(frame_err),
        .err_cnt(err_cnt), .busy(busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: bytes of the frame in progress are kept in a queue;
    // the frame is judged once it holds 13 (checksum) or 14 (tail) bytes.
    logic [7:0] m_frame[$];
    int         m_silent;
    logic [7:0] m_func;
    logic [7:0] m_data [10];
    int         m_err;
    bit         m_pd, m_fe;

    task automatic model_clear();
        m_frame.delete();
        m_silent = 0;
        m_func   = 8'h00;
        for (int i = 0; i < 10; i++) m_data[i] = 8'h00;
        m_err = 0;
        m_pd  = 1'b0;
        m_fe  = 1'b0;
    endtask

    task automatic model_err();
        m_fe = 1'b1;
        if (m_err < 255) m_err++;
        m_frame.delete();
        m_silent = 0;
    endtask

    task automatic model_step(input bit d, input logic [7:0] b);
        int s;
        m_pd = 1'b0;
        m_fe = 1'b0;
        if (d) begin
            m_silent = 0;
            if (m_frame.size() == 0) begin
                if (b == 8'hA5) m_frame.push_back(b);
            end else begin
                m_frame.push_back(b);
                if (m_frame.size() == 13) begin
                    s = 0;
                    for (int i = 1; i <= 11; i++) s += int'(m_frame[i]);
                    if ((s % 256) != int'(b)) model_err();
                end else if (m_frame.size() == 14) begin
                    if (b == 8'h5A) begin
                        m_func = m_frame[1];
                        for (int i = 0; i < 10; i++) m_data[i] = m_frame[i+2];
                        m_pd = 1'b1;
                        m_frame.delete();
                    end else begin
                        model_err();
                    end
                end
            end
        end else if (m_frame.size() != 0) begin
            m_silent++;
            if (m_silent >= T) model_err();
        end
    endtask

    task automatic check_outputs();
        chk_eq("pack_done", {31'd0, pack_done}, {31'd0, m_pd});
        chk_eq("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
        chk_eq("err_cnt", {24'd0, err_cnt}, 32'(m_err));
        chk_eq("busy", {31'd0, busy}, {31'd0, m_frame.size() != 0});
        chk_eq("func_reg", {24'd0, func_reg}, {24'd0, m_func});
        for (int i = 0; i < 10; i++)
            chk_eq($sformatf("rev_data%0d", i + 1), {24'd0, rd[i]}, {24'd0, m_data[i]});
    endtask

    // One clock cycle: drive inputs just after an edge, check just after the next.
    task automatic tick(input bit d, input logic [7:0] b);
        uart_rx_done = d;
        uart_rx_data = d ? b : 8'($urandom);
        model_step(d, b);
        @(posedge clk_50M);
        #1;
        uart_rx_done = 1'b0;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        #1;
        check_outputs();
        @(posedge clk_50M);
        #1;
        rst = 1'b0;
        check_outputs();
    endtask

    logic [7:0] tx_q[$];
    logic [7:0] pay [10];

    // kind: 0 valid, 1 bad checksum, 2 bad tail
    task automatic mk_frame(input logic [7:0] f, input int kind);
        logic [7:0] cs;
        cs = f;
        for (int i = 0; i < 10; i++) cs = cs + pay[i];
        tx_q.delete();
        tx_q.push_back(8'hA5);
        tx_q.push_back(f);
        for (int i = 0; i < 10; i++) tx_q.push_back(pay[i]);
        tx_q.push_back(kind == 1 ? cs + 8'd1 : cs);
        tx_q.push_back(kind == 2 ? 8'h5B : 8'h5A);
    endtask

    function automatic int pick_gap();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return T - 1;
        if (r == 1) return T;
        return int'($urandom_range(0, 2));
    endfunction

    // gap < 0 selects a random gap before every byte
    task automatic send_q(input int gap);
        int g;
        for (int i = 0; i < tx_q.size(); i++) begin
            g = (gap < 0) ? pick_gap() : gap;
            repeat (g) tick(1'b0, 8'h00);
            tick(1'b1, tx_q[i]);
        end
    endtask

    task automatic set_pay(input logic [79:0] v);
        for (int i = 0; i < 10; i++) pay[i] = v[79 - 8*i -: 8];
    endtask

    initial begin
        do_reset();
        repeat (2) tick(1'b0, 8'h00);

        // Valid frame
        set_pay(80'h02_00_10_00_20_05_DE_AD_BE_EF);
        mk_frame(8'h01, 0);
        send_q(0);
        chk_eq("tp_func", {24'd0, func_reg}, 32'h01);
        chk_eq("tp_d1", {24'd0, rev_data1}, 32'h02);
        chk_eq("tp_d10", {24'd0, rev_data10}, 32'hEF);
        chk_eq("tp_errcnt0", {24'd0, err_cnt}, 32'h00);
        repeat (2) tick(1'b0, 8'h00);

        // Bad checksum: previous outputs must hold
        mk_frame(8'h01, 1);
        tx_q[12] = 8'h90;
        send_q(0);
        chk_eq("tp_errcnt1", {24'd0, err_cnt}, 32'h01);
        repeat (2) tick(1'b0, 8'h00);

        // Timeout after three bytes, then a normal frame
        tick(1'b1, 8'hA5);
        tick(1'b1, 8'h02);
        tick(1'b1, 8'h03);
        repeat (T + 2) tick(1'b0, 8'h00);
        chk_eq("tp_tmo_busy", {31'd0, busy}, 32'd0);
        set_pay(80'h11_22_33_44_55_66_77_88_99_AA);
        mk_frame(8'h07, 0);
        send_q(1);

        // Noise, embedded header as data, bad tail
        tick(1'b1, 8'h00);
        tick(1'b1, 8'hFF);
        set_pay(80'h01_02_A5_04_05_06_07_08_09_0A);
        mk_frame(8'h33, 0);
        send_q(0);
        chk_eq("tp_d3_hdr", {24'd0, rev_data3}, 32'hA5);
        mk_frame(8'h34, 2);
        send_q(0);

        // Inter-byte gap boundary: T-1 silent cycles still accepted, T times out
        set_pay(80'hF0_E1_D2_C3_B4_A5_96_87_78_69);
        mk_frame(8'h44, 0);
        send_q(T - 1);
        mk_frame(8'h45, 0);
        send_q(T);
        repeat (3) tick(1'b0, 8'h00);

        // Reset mid-frame, then back-to-back frames
        mk_frame(8'h55, 0);
        for (int i = 0; i < 6; i++) tick(1'b1, tx_q[i]);
        do_reset();
        chk_eq("tp_rst_err", {24'd0, err_cnt}, 32'h00);
        chk_eq("tp_rst_func", {24'd0, func_reg}, 32'h00);
        set_pay(80'h10_20_30_40_50_60_70_80_90_A0);
        mk_frame(8'h61, 0);
        send_q(0);
        set_pay(80'hAB_CD_EF_01_23_45_67_89_0F_F0);
        mk_frame(8'h62, 0);
        send_q(0);
        chk_eq("tp_b2b_func", {24'd0, func_reg}, 32'h62);

        // Error count saturation
        for (int n = 0; n < 256; n++) begin
            mk_frame(8'($urandom), 2);
            send_q(0);
        end
        chk_eq("tp_sat", {24'd0, err_cnt}, 32'hFF);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 80; n++) begin
            int kind;
            kind = int'($urandom_range(0, 5));
            for (int i = 0; i < 10; i++) pay[i] = 8'($urandom);
            if (kind == 4) begin
                repeat (int'($urandom_range(1, 4))) tick(1'b1, 8'($urandom));
            end
            mk_frame(8'($urandom), (kind > 2) ? 0 : kind);
            if (kind == 5) begin
                int keep;
                keep = int'($urandom_range(1, 13));
                while (tx_q.size() > keep) void'(tx_q.pop_back());
                send_q(0);
                repeat (T + int'($urandom_range(0, 3))) tick(1'b0, 8'h00);
            end else begin
                send_q(-1);
            end
            repeat (int'($urandom_range(0, 3))) tick(1'b0, 8'h00);
        end
        repeat (T + 2) tick(1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
